// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, phase encoding and helpers for the VGA raster timing generator.
package vga_timing_gen_pkg;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;

    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Both axes fit in 10 bits (800 columns, 525 lines).
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus active/front-porch/sync/back-porch phase tracker.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACT  = DEF_H_ACT,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       phase,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACT - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACT + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACT + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(ACT + FP + SYNC + BP - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    phase_e           phase_q;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase advances on the last count of each region, so it always agrees with cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ACT;
        end else if (step) begin
            case (phase_q)
                PH_ACT:  if (cnt_q == END_ACT)  phase_q <= PH_FP;
                PH_FP:   if (cnt_q == END_FP)   phase_q <= PH_SYNC;
                PH_SYNC: if (cnt_q == END_SYNC) phase_q <= PH_BP;
                PH_BP:   if (cnt_q == LAST)     phase_q <= PH_ACT;
                default: phase_q <= PH_ACT;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;
    assign wrap  = step && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: registered active flag, scaled pixel position,
// delayed sync outputs and frame bookkeeping built on two axis counters.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   LOC_WIDTH   = 9,
    parameter int   SCALE_SHIFT = 1,
    parameter int   SYNC_DELAY  = 1,
    parameter int   H_ACT       = DEF_H_ACT,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACT       = DEF_V_ACT,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic                 clk25MHz,
    input  logic                 rst,
    output logic [LOC_WIDTH-1:0] pos_x,
    output logic [LOC_WIDTH-1:0] pos_y,
    output logic                 active,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [7:0]           frame_count
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [1:0]       h_phase;
    logic [1:0]       v_phase;
    logic             h_wrap;
    logic             v_wrap_unused;

    vga_axis_counter #(
        .ACT (H_ACT),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP)
    ) u_h_axis (
        .clk  (clk25MHz),
        .rst  (rst),
        .step (1'b1),
        .cnt  (h_cnt),
        .phase(h_phase),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .ACT (V_ACT),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP)
    ) u_v_axis (
        .clk  (clk25MHz),
        .rst  (rst),
        .step (h_wrap),
        .cnt  (v_cnt),
        .phase(v_phase),
        .wrap (v_wrap_unused)
    );

    logic                 active_q,      active_d;
    logic [LOC_WIDTH-1:0] pos_x_q,       pos_x_d;
    logic [LOC_WIDTH-1:0] pos_y_q,       pos_y_d;
    logic                 line_start_q,  line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic [7:0]           frame_count_q, frame_count_d;
    logic                 first_frame_q, first_frame_d;
    logic [SYNC_DELAY:0]  hs_pipe_q,     hs_pipe_d;
    logic [SYNC_DELAY:0]  vs_pipe_q,     vs_pipe_d;

    always_comb begin
        active_d      = (h_phase == PH_ACT) && (v_phase == PH_ACT);
        pos_x_d       = '0;
        pos_y_d       = '0;
        if (active_d) begin
            pos_x_d = LOC_WIDTH'(h_cnt >> SCALE_SHIFT);
            pos_y_d = LOC_WIDTH'(v_cnt >> SCALE_SHIFT);
        end
        line_start_d  = active_d && (h_cnt == '0);
        frame_start_d = line_start_d && (v_cnt == '0);

        // The very first frame after reset is not counted as completed.
        first_frame_d = first_frame_q && !frame_start_d;
        frame_count_d = frame_count_q;
        if (frame_start_d && !first_frame_q) begin
            frame_count_d = frame_count_q + 8'd1;
        end

        // Stage 0 is aligned with active; each further stage adds one cycle.
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        hs_pipe_d[0] = sync_level(h_phase == PH_SYNC, SYNC_POL);
        vs_pipe_d[0] = sync_level(v_phase == PH_SYNC, SYNC_POL);
        for (int i = 1; i <= SYNC_DELAY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            active_q      <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            first_frame_q <= 1'b1;
            hs_pipe_q     <= {(SYNC_DELAY+1){~SYNC_POL}};
            vs_pipe_q     <= {(SYNC_DELAY+1){~SYNC_POL}};
        end else begin
            active_q      <= active_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            first_frame_q <= first_frame_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
        end
    end

    assign active      = active_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign hsync       = hs_pipe_q[SYNC_DELAY];
    assign vsync       = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: vector table over the first frame plus
// hand-written reset, mid-frame reset and frame-counter wrap sequences.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // a_: SYNC_DELAY=1, z_: SYNC_DELAY=0, t_: SYNC_DELAY=3 (full-width lines, 12-line frame)
    // s_: tiny 8x7 raster used to spin through 257 frames quickly
    logic [8:0] a_pos_x, a_pos_y, z_pos_x, z_pos_y, t_pos_x, t_pos_y, s_pos_x, s_pos_y;
    logic       a_active, a_hsync, a_vsync, a_line_start, a_frame_start;
    logic       z_active, z_hsync, z_vsync, z_line_start, z_frame_start;
    logic       t_active, t_hsync, t_vsync, t_line_start, t_frame_start;
    logic       s_active, s_hsync, s_vsync, s_line_start, s_frame_start;
    logic [7:0] a_frame_count, z_frame_count, t_frame_count, s_frame_count;

    vga_timing_gen #(.SYNC_DELAY(1), .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
        .clk25MHz(clk), .rst(rst), .pos_x(a_pos_x), .pos_y(a_pos_y), .active(a_active),
        .hsync(a_hsync), .vsync(a_vsync), .line_start(a_line_start),
        .frame_start(a_frame_start), .frame_count(a_frame_count));

    vga_timing_gen #(.SYNC_DELAY(0), .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_z (
        .clk25MHz(clk), .rst(rst), .pos_x(z_pos_x), .pos_y(z_pos_y), .active(z_active),
        .hsync(z_hsync), .vsync(z_vsync), .line_start(z_line_start),
        .frame_start(z_frame_start), .frame_count(z_frame_count));

    vga_timing_gen #(.SYNC_DELAY(3), .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_t (
        .clk25MHz(clk), .rst(rst), .pos_x(t_pos_x), .pos_y(t_pos_y), .active(t_active),
        .hsync(t_hsync), .vsync(t_vsync), .line_start(t_line_start),
        .frame_start(t_frame_start), .frame_count(t_frame_count));

    vga_timing_gen #(.H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_s (
        .clk25MHz(clk), .rst(rst), .pos_x(s_pos_x), .pos_y(s_pos_y), .active(s_active),
        .hsync(s_hsync), .vsync(s_vsync), .line_start(s_line_start),
        .frame_start(s_frame_start), .frame_count(s_frame_count));

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int   n;
        logic act;
        int   px;
        int   py;
        logic ls;
        logic fs;
        int   fc;
        logic hs0;
        logic hs1;
        logic hs3;
        logic vs1;
    } vec_t;

    vec_t vecs[21];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "/active"},      a_active,      0);
        check_output({tag, "/pos_x"},       a_pos_x,       0);
        check_output({tag, "/pos_y"},       a_pos_y,       0);
        check_output({tag, "/line_start"},  a_line_start,  0);
        check_output({tag, "/frame_start"}, a_frame_start, 0);
        check_output({tag, "/frame_count"}, a_frame_count, 0);
        check_output({tag, "/hsync_d1"},    a_hsync,       1);
        check_output({tag, "/vsync_d1"},    a_vsync,       1);
        check_output({tag, "/hsync_d0"},    z_hsync,       1);
        check_output({tag, "/hsync_d3"},    t_hsync,       1);
    endtask

    task automatic check_first_edge(input string tag);
        check_output({tag, "/active"},      a_active,      1);
        check_output({tag, "/pos_x"},       a_pos_x,       0);
        check_output({tag, "/pos_y"},       a_pos_y,       0);
        check_output({tag, "/frame_start"}, a_frame_start, 1);
        check_output({tag, "/line_start"},  a_line_start,  1);
        check_output({tag, "/frame_count"}, a_frame_count, 0);
    endtask

    task automatic apply_stimulus(input int n, input vec_t v);
        check_output($sformatf("active@%0d", n),      a_active,      v.act);
        check_output($sformatf("pos_x@%0d", n),       a_pos_x,       v.px);
        check_output($sformatf("pos_y@%0d", n),       a_pos_y,       v.py);
        check_output($sformatf("line_start@%0d", n),  a_line_start,  v.ls);
        check_output($sformatf("frame_start@%0d", n), a_frame_start, v.fs);
        check_output($sformatf("frame_count@%0d", n), a_frame_count, v.fc);
        check_output($sformatf("hsync_d0@%0d", n),    z_hsync,       v.hs0);
        check_output($sformatf("hsync_d1@%0d", n),    a_hsync,       v.hs1);
        check_output($sformatf("hsync_d3@%0d", n),    t_hsync,       v.hs3);
        check_output($sformatf("vsync_d1@%0d", n),    a_vsync,       v.vs1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vi;
        int act_line0, hs_low_line0, vs_low, ls_count;
        int act_fall, fall0, fall1, fall3, fs_second, ls_second;

        // n = cycles since release; outputs at n reflect raw counter index n
        //          n    act px   py ls fs fc hs0 hs1 hs3 vs1
        vecs[0]  = '{0,    1, 0,   0, 1, 1, 0, 1,  1,  1,  1};
        vecs[1]  = '{2,    1, 1,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[2]  = '{639,  1, 319, 0, 0, 0, 0, 1,  1,  1,  1};
        vecs[3]  = '{640,  0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[4]  = '{656,  0, 0,   0, 0, 0, 0, 0,  1,  1,  1};
        vecs[5]  = '{657,  0, 0,   0, 0, 0, 0, 0,  0,  1,  1};
        vecs[6]  = '{659,  0, 0,   0, 0, 0, 0, 0,  0,  0,  1};
        vecs[7]  = '{752,  0, 0,   0, 0, 0, 0, 1,  0,  0,  1};
        vecs[8]  = '{753,  0, 0,   0, 0, 0, 0, 1,  1,  0,  1};
        vecs[9]  = '{755,  0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[10] = '{800,  1, 0,   0, 1, 0, 0, 1,  1,  1,  1};
        vecs[11] = '{801,  1, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[12] = '{1602, 1, 1,   1, 0, 0, 0, 1,  1,  1,  1};
        vecs[13] = '{6239, 1, 319, 3, 0, 0, 0, 1,  1,  1,  1};
        vecs[14] = '{6400, 0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[15] = '{7200, 0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[16] = '{7201, 0, 0,   0, 0, 0, 0, 1,  1,  1,  0};
        vecs[17] = '{8800, 0, 0,   0, 0, 0, 0, 1,  1,  1,  0};
        vecs[18] = '{8801, 0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[19] = '{9599, 0, 0,   0, 0, 0, 0, 1,  1,  1,  1};
        vecs[20] = '{9600, 1, 0,   0, 1, 1, 1, 1,  1,  1,  1};

        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_reset($sformatf("reset%0d", c));
        end
        rst = 1'b0;

        vi = 0;
        act_line0 = 0; hs_low_line0 = 0; vs_low = 0; ls_count = 0;
        act_fall = -1; fall0 = -1; fall1 = -1; fall3 = -1; fs_second = -1; ls_second = -1;
        for (int n = 0; n <= 9600; n++) begin
            tick();
            if (n == 0) check_first_edge("release");
            if (vi < 21 && vecs[vi].n == n) begin
                apply_stimulus(n, vecs[vi]);
                vi++;
            end
            if (n < 800) begin
                if (a_active) act_line0++;
                if (!a_hsync) hs_low_line0++;
            end
            if (act_fall < 0 && !a_active) act_fall = n;
            if (fall0 < 0 && !z_hsync) fall0 = n;
            if (fall1 < 0 && !a_hsync) fall1 = n;
            if (fall3 < 0 && !t_hsync) fall3 = n;
            if (!a_vsync) vs_low++;
            if (a_line_start && n < 9600) ls_count++;
            if (a_line_start && n > 0 && ls_second < 0) ls_second = n;
            if (a_frame_start && n > 0 && fs_second < 0) fs_second = n;
        end
        check_output("active_cycles_line0", act_line0, 640);
        check_output("hsync_low_cycles",    hs_low_line0, 96);
        check_output("line_period",         ls_second, 800);
        check_output("hsync_fall_d1",       fall1, 657);
        check_output("active_fall",         act_fall, 640);
        check_output("hsync_lag_d0",        fall0 - act_fall, 16);
        check_output("hsync_lag_d3",        fall3 - act_fall, 19);
        check_output("frame_period",        fs_second, 9600);
        check_output("vsync_low_cycles",    vs_low, 1600);
        check_output("line_starts_per_frame", ls_count, 8);

        // Walk to raw h=700, v=5 of the second frame, inside the hsync pulse.
        for (int n = 9601; n <= 14300; n++) tick();
        check_output("pre_rst/hsync_d1",    a_hsync, 0);
        check_output("pre_rst/hsync_d0",    z_hsync, 0);
        check_output("pre_rst/hsync_d3",    t_hsync, 0);
        check_output("pre_rst/frame_count", a_frame_count, 1);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_reset($sformatf("midrst%0d", c));
        end
        rst = 1'b0;
        tick();
        check_first_edge("restart");
        check_output("restart/hsync_d3", t_hsync, 1);
        check_output("small/frame_start@0", s_frame_start, 1);
        check_output("small/frame_count@0", s_frame_count, 0);

        // Small raster: 56 cycles per frame, so frame k starts at n = 56*k.
        for (int n = 1; n <= 14336; n++) begin
            tick();
            case (n)
                55: check_output("small/frame_count@55", s_frame_count, 0);
                56: begin
                    check_output("small/frame_start@56", s_frame_start, 1);
                    check_output("small/frame_count@56", s_frame_count, 1);
                end
                14279: check_output("small/frame_count@14279", s_frame_count, 254);
                14280: begin
                    check_output("small/frame_start@14280", s_frame_start, 1);
                    check_output("small/frame_count@14280", s_frame_count, 255);
                end
                14335: check_output("small/frame_count@14335", s_frame_count, 255);
                14336: begin
                    check_output("small/frame_start@14336", s_frame_start, 1);
                    check_output("small/frame_count_wrap", s_frame_count, 0);
                end
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
